// File: rtl/temp_pkg.sv
// Shared constants, FSM state type and the reading clamp for the temperature sensor reader.
package temp_pkg;

    localparam int unsigned TEMP_W   = 10;
    localparam int unsigned TEMP_MAX = 999;
    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned SIGN_BIT = 15;
    localparam int unsigned MAG_MSB  = 14;
    localparam int unsigned MAG_LSB  = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        PROC
    } state_t;

    typedef struct packed {
        logic [TEMP_W-1:0] value;
        logic              over;
    } reading_t;

    // Negative readings floor at 0; magnitudes beyond the display range saturate and flag.
    function automatic reading_t clamp_frame(input logic [FRAME_W-1:0] frame);
        reading_t          r;
        logic [TEMP_W-1:0] mag;
        mag    = frame[MAG_MSB:MAG_LSB];
        r.over = 1'b0;
        if (frame[SIGN_BIT]) begin
            r.value = '0;
        end else if (mag > TEMP_W'(TEMP_MAX)) begin
            r.value = TEMP_W'(TEMP_MAX);
            r.over  = 1'b1;
        end else begin
            r.value = mag;
        end
        return r;
    endfunction

endpackage

// File: rtl/temp_sensor_reader_if.sv
// Sensor pins plus the averaged temperature bus toward the display driver.
interface temp_sensor_reader_if;
    import temp_pkg::*;

    logic              sensor_miso;
    logic              sensor_sclk;
    logic              sensor_cs_n;
    logic [TEMP_W-1:0] temp_data;
    logic              temp_valid;
    logic              overrange;

    modport master (
        input  sensor_miso,
        output sensor_sclk,
        output sensor_cs_n,
        output temp_data,
        output temp_valid,
        output overrange
    );

    modport slave (
        output sensor_miso,
        input  sensor_sclk,
        input  sensor_cs_n,
        input  temp_data,
        input  temp_valid,
        input  overrange
    );

endinterface

// File: rtl/spi_rx_frame.sv
// SPI mode-0 read-only frame receiver: chip-select setup, 16 SCLK periods, hold, then a done pulse.
module spi_rx_frame
    import temp_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               miso,
    output logic               sclk,
    output logic               cs_n,
    output logic               done,
    output logic [FRAME_W-1:0] frame
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               div_end;

    assign div_end = (div_cnt == DIV_LAST);
    assign frame   = shreg;

    // Every phase lasts CLK_DIV cycles; MISO is captured on the edge that raises SCLK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cs_n    <= 1'b0;
                        div_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            shreg <= {shreg[FRAME_W-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic sensor poll with clamping and a power-of-two window average feeding the display driver.
module temp_sensor_reader
    import temp_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    temp_sensor_reader_if.master  bus
);

    localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
    localparam int unsigned ACC_W = TEMP_W + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    state_t             state;
    logic [PER_W-1:0]   period_cnt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   rd_cnt;
    logic               win_over;
    logic               start_c;
    logic               rx_done;
    logic [FRAME_W-1:0] rx_frame;
    reading_t           rd_c;
    logic [ACC_W-1:0]   sum_c;
    logic               last_c;

    assign start_c = (state == IDLE) && (period_cnt == '0);
    assign rd_c    = clamp_frame(rx_frame);
    assign sum_c   = acc + ACC_W'(rd_c.value);
    assign last_c  = (AVG_LOG2 == 0) || (rd_cnt == '1);

    spi_rx_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .miso  (bus.sensor_miso),
        .sclk  (bus.sensor_sclk),
        .cs_n  (bus.sensor_cs_n),
        .done  (rx_done),
        .frame (rx_frame)
    );

    // Free-running sample timer; wrapping to 0 requests a transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (period_cnt == PER_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PER_W'(1);
        end
    end

    // Results are registered on entry to PROC so temp_valid is high during PROC itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            acc            <= '0;
            rd_cnt         <= '0;
            win_over       <= 1'b0;
            bus.temp_data  <= '0;
            bus.temp_valid <= 1'b0;
            bus.overrange  <= 1'b0;
        end else begin
            bus.temp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rx_done) begin
                        state <= PROC;
                        if (last_c) begin
                            bus.temp_data  <= TEMP_W'(sum_c >> AVG_LOG2);
                            bus.overrange  <= win_over | rd_c.over;
                            bus.temp_valid <= 1'b1;
                            acc            <= '0;
                            rd_cnt         <= '0;
                            win_over       <= 1'b0;
                        end else begin
                            acc      <= sum_c;
                            rd_cnt   <= rd_cnt + CNT_W'(1);
                            win_over <= win_over | rd_c.over;
                        end
                    end
                end
                PROC: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
